// File: rtl/operand_entry_seq_pkg.sv
// Shared types and constants for the operand entry sequencer.
// Slot sentinel, FSM state encoding (stage == state) and key event codes.
package operand_entry_pkg;

   localparam logic [3:0] EMPTY_CODE = 4'hF;
   localparam int         NUM_SLOTS  = 3;

   localparam int SLOT_A  = 0;
   localparam int SLOT_OP = 1;
   localparam int SLOT_B  = 2;

   localparam int NUM_KEYS  = 2;
   localparam int KEY_ENTER = 0;
   localparam int KEY_CLEAR = 1;

   typedef enum logic [1:0] {
      GET_A  = 2'd0,
      GET_OP = 2'd1,
      GET_B  = 2'd2,
      FULL   = 2'd3
   } entry_state_t;

   typedef enum logic [1:0] {
      EV_NONE  = 2'd0,
      EV_PRESS = 2'd1,
      EV_HOLD  = 2'd2
   } key_event_t;

endpackage

// File: rtl/operand_entry_seq_if.sv
// Entry/ALU-side bundle of the operand entry sequencer.
// master = the sequencer, slave = the consumer (display/ALU side).
interface operand_entry_seq_if;
   import operand_entry_pkg::*;

   logic [3:0]                sw;
   logic                      alu_ack;
   logic [NUM_SLOTS-1:0][3:0] values;
   logic [1:0]                stage;
   logic                      triple_valid;
   logic                      entry_err;

   modport master (
      input  sw, alu_ack,
      output values, stage, triple_valid, entry_err
   );

   modport slave (
      output sw, alu_ack,
      input  values, stage, triple_valid, entry_err
   );

endinterface

// File: rtl/operand_entry_seq_key_debounce.sv
// Per-key conditioning: 2-FF synchronizer, stability counter, press pulse and
// an optional long-hold pulse (HOLD_CYCLES = 0 removes the hold counter).
module key_debounce
   import operand_entry_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int HOLD_CYCLES     = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_n,
   output key_event_t evt
);

   localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_reg;
   logic             sync2_reg;
   logic             level_reg;
   logic             level_d_reg;
   logic [CNT_W-1:0] cnt_reg;
   key_event_t       evt_reg;
   logic             hold_fire;

   // Everything resets to the released (high) level so reset never yields a press.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_reg   <= 1'b1;
         sync2_reg   <= 1'b1;
         level_reg   <= 1'b1;
         level_d_reg <= 1'b1;
         cnt_reg     <= '0;
         evt_reg     <= EV_NONE;
      end else begin
         sync1_reg   <= key_n;
         sync2_reg   <= sync1_reg;
         level_d_reg <= level_reg;
         if (sync2_reg != level_reg) begin
            if (cnt_reg == CNT_MAX) begin
               level_reg <= sync2_reg;
               cnt_reg   <= '0;
            end else begin
               cnt_reg <= cnt_reg + CNT_W'(1);
            end
         end else begin
            cnt_reg <= '0;
         end
         if (level_d_reg && !level_reg)
            evt_reg <= EV_PRESS;
         else if (hold_fire)
            evt_reg <= EV_HOLD;
         else
            evt_reg <= EV_NONE;
      end
   end

   generate
      if (HOLD_CYCLES > 0) begin : g_hold
         localparam int               HOLD_W   = $clog2(HOLD_CYCLES + 1);
         localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);

         logic [HOLD_W-1:0] hold_cnt_reg;

         // Saturating count of debounced-low cycles; fires once on the way up.
         always_ff @(posedge clk or posedge rst) begin
            if (rst)
               hold_cnt_reg <= '0;
            else if (level_reg)
               hold_cnt_reg <= '0;
            else if (hold_cnt_reg != HOLD_MAX)
               hold_cnt_reg <= hold_cnt_reg + HOLD_W'(1);
         end

         assign hold_fire = !level_reg && (hold_cnt_reg == HOLD_MAX - HOLD_W'(1));
      end else begin : g_no_hold
         assign hold_fire = 1'b0;
      end
   endgenerate

   assign evt = evt_reg;

endmodule

// File: rtl/operand_entry_seq.sv
// Captures operand A, opcode and operand B from switches on debounced ENTER and
// hands the triple to the ALU. OPERAND_ENTRY_UNDO_EN turns CLEAR into backspace.
module operand_entry_seq
   import operand_entry_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       key_enter_n,
   input  logic                       key_clear_n,
   operand_entry_seq_if.master        bus
);

`ifdef OPERAND_ENTRY_UNDO_EN
   localparam int CLEAR_HOLD_CYCLES = 4 * DEBOUNCE_CYCLES;
`else
   localparam int CLEAR_HOLD_CYCLES = 0;
`endif

   logic         raw_keys [NUM_KEYS];
   key_event_t   key_evt  [NUM_KEYS];

   entry_state_t state_reg;
   entry_state_t state_next;
   logic [3:0]   values_reg  [NUM_SLOTS];
   logic [3:0]   values_next [NUM_SLOTS];
   logic         slot_load   [NUM_SLOTS];
   logic         slot_undo   [NUM_SLOTS];
   logic         triple_valid_reg;
   logic         triple_valid_next;
   logic         entry_err_reg;
   logic         entry_err_next;

   logic         enter_press;
   logic         full_clear;
   logic         undo_req;
   logic         clear_all;
   logic         load_en;
   logic         undo_en;

   assign raw_keys[KEY_ENTER] = key_enter_n;
   assign raw_keys[KEY_CLEAR] = key_clear_n;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_KEYS; gi++) begin : g_key
         key_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     ((gi == KEY_CLEAR) ? CLEAR_HOLD_CYCLES : 0)
         ) u_debounce (
            .clk   (clk),
            .rst   (rst),
            .key_n (raw_keys[gi]),
            .evt   (key_evt[gi])
         );
      end
   endgenerate

   assign enter_press = (key_evt[KEY_ENTER] == EV_PRESS);
`ifdef OPERAND_ENTRY_UNDO_EN
   assign full_clear  = (key_evt[KEY_CLEAR] == EV_HOLD);
   assign undo_req    = (key_evt[KEY_CLEAR] == EV_PRESS);
`else
   assign full_clear  = (key_evt[KEY_CLEAR] == EV_PRESS);
   assign undo_req    = 1'b0;
`endif

   // Priority: full clear, backspace, ALU ack, ENTER. CLEAR therefore beats ENTER.
   always_comb begin
      state_next     = state_reg;
      clear_all      = 1'b0;
      load_en        = 1'b0;
      undo_en        = 1'b0;
      entry_err_next = 1'b0;
      if (full_clear) begin
         clear_all  = 1'b1;
         state_next = GET_A;
      end else if (undo_req) begin
         if (state_reg != GET_A) begin
            undo_en    = 1'b1;
            state_next = entry_state_t'(state_reg - 2'd1);
         end
      end else if (bus.alu_ack && (state_reg == FULL)) begin
         clear_all  = 1'b1;
         state_next = GET_A;
      end else if (enter_press && (state_reg != FULL)) begin
         if (bus.sw == EMPTY_CODE) begin
            entry_err_next = 1'b1;
         end else begin
            load_en    = 1'b1;
            state_next = entry_state_t'(state_reg + 2'd1);
         end
      end
      triple_valid_next = (state_next == FULL);
   end

   // Slot i is written while in state i and emptied when backing out of state i+1.
   generate
      for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
         assign slot_load[gi]   = load_en && (state_reg == entry_state_t'(gi));
         assign slot_undo[gi]   = undo_en && (state_reg == entry_state_t'(gi + 1));
         assign values_next[gi] = (clear_all || slot_undo[gi]) ? EMPTY_CODE :
                                  slot_load[gi]                ? bus.sw     :
                                                                 values_reg[gi];
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg        <= GET_A;
         triple_valid_reg <= 1'b0;
         entry_err_reg    <= 1'b0;
         for (int i = 0; i < NUM_SLOTS; i++)
            values_reg[i] <= EMPTY_CODE;
      end else begin
         state_reg        <= state_next;
         triple_valid_reg <= triple_valid_next;
         entry_err_reg    <= entry_err_next;
         for (int i = 0; i < NUM_SLOTS; i++)
            values_reg[i] <= values_next[i];
      end
   end

   assign bus.values       = {values_reg[SLOT_B], values_reg[SLOT_OP], values_reg[SLOT_A]};
   assign bus.stage        = state_reg;
   assign bus.triple_valid = triple_valid_reg;
   assign bus.entry_err    = entry_err_reg;

endmodule

// File: tb/tb_operand_entry_seq.sv
// Directed bench for operand_entry_seq with DEBOUNCE_CYCLES = 4; CLEAR
// expectations follow OPERAND_ENTRY_UNDO_EN when that macro is defined.
module tb_operand_entry_seq;

   localparam int D = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic key_enter_n = 1'b1;
   logic key_clear_n = 1'b1;

   int checks = 0;
   int errors = 0;
   int err_pulses = 0;

   operand_entry_seq_if bus_if ();

   operand_entry_seq #(.DEBOUNCE_CYCLES(D)) dut (
      .clk         (clk),
      .rst         (rst),
      .key_enter_n (key_enter_n),
      .key_clear_n (key_clear_n),
      .bus         (bus_if)
   );

   always #5 clk = ~clk;

   always @(posedge clk)
      if (bus_if.entry_err === 1'b1) err_pulses++;

   // Advance n active edges, then sit 1 time unit past the last one.
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
      $display("check %-18s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Clean press held long enough to debounce, then released and allowed to settle.
   task automatic press_enter(input logic [3:0] value);
      bus_if.sw   = value;
      key_enter_n = 1'b0;
      tick(D + 8);
      key_enter_n = 1'b1;
      tick(D + 8);
   endtask

   task automatic press_clear(input int low_cycles);
      key_clear_n = 1'b0;
      tick(low_cycles);
      key_clear_n = 1'b1;
      tick(D + 10);
   endtask

   initial begin
      bus_if.sw      = 4'h0;
      bus_if.alu_ack = 1'b0;
      tick(3);
      rst = 1'b0;
      tick(50);
      check("reset_values", 32'(bus_if.values), 32'hFFF);
      check("reset_stage", 32'(bus_if.stage), 32'd0);
      check("reset_valid", 32'(bus_if.triple_valid), 32'd0);
      check("reset_no_err", 32'(err_pulses), 32'd0);

      // First press with exact latency: event at edge D+3, values on edge D+4.
      bus_if.sw   = 4'h3;
      key_enter_n = 1'b0;
      tick(D + 3);
      check("latency_before", 32'(bus_if.values), 32'hFFF);
      tick(1);
      check("latency_capture", 32'(bus_if.values), 32'hFF3);
      tick(4);
      key_enter_n = 1'b1;
      tick(D + 8);
      check("stage_after_a", 32'(bus_if.stage), 32'd1);

      press_enter(4'h5);
      check("values_a_op", 32'(bus_if.values), 32'hF53);
      check("stage_after_op", 32'(bus_if.stage), 32'd2);
      check("valid_not_full", 32'(bus_if.triple_valid), 32'd0);

      press_enter(4'h9);
      check("values_full", 32'(bus_if.values), 32'h953);
      check("stage_full", 32'(bus_if.stage), 32'd3);
      check("valid_full", 32'(bus_if.triple_valid), 32'd1);

      press_enter(4'h7);
      check("enter_in_full", 32'(bus_if.values), 32'h953);
      check("stage_still_full", 32'(bus_if.stage), 32'd3);
      check("full_enter_no_err", 32'(err_pulses), 32'd0);

      bus_if.alu_ack = 1'b1;
      tick(1);
      bus_if.alu_ack = 1'b0;
      check("ack_values", 32'(bus_if.values), 32'hFFF);
      check("ack_stage", 32'(bus_if.stage), 32'd0);
      check("ack_valid", 32'(bus_if.triple_valid), 32'd0);

      bus_if.alu_ack = 1'b1;
      tick(1);
      bus_if.alu_ack = 1'b0;
      tick(2);
      check("ack_in_get_a_stage", 32'(bus_if.stage), 32'd0);
      check("ack_in_get_a_vals", 32'(bus_if.values), 32'hFFF);

      // Bounce: 1-cycle glitches for 10 cycles, then a solid hold.
      bus_if.sw = 4'h6;
      for (int i = 0; i < 10; i++) begin
         key_enter_n = (i % 2 == 0) ? 1'b0 : 1'b1;
         tick(1);
      end
      key_enter_n = 1'b1;
      tick(D + 4);
      check("bounce_no_capture", 32'(bus_if.values), 32'hFFF);
      key_enter_n = 1'b0;
      tick(D + 10);
      key_enter_n = 1'b1;
      tick(D + 8);
      check("bounce_one_value", 32'(bus_if.values), 32'hFF6);
      check("bounce_one_stage", 32'(bus_if.stage), 32'd1);

      // Empty-code ENTER in GET_OP.
      press_enter(4'hF);
      check("err_one_cycle", 32'(err_pulses), 32'd1);
      check("err_values", 32'(bus_if.values), 32'hFF6);
      check("err_stage", 32'(bus_if.stage), 32'd1);

      press_enter(4'h5);
      press_enter(4'h9);
      check("refill_values", 32'(bus_if.values), 32'h956);
      check("refill_valid", 32'(bus_if.triple_valid), 32'd1);

      press_clear(8);
`ifdef OPERAND_ENTRY_UNDO_EN
      check("undo_values", 32'(bus_if.values), 32'hF56);
      check("undo_stage", 32'(bus_if.stage), 32'd2);
      check("undo_valid", 32'(bus_if.triple_valid), 32'd0);
      press_enter(4'h9);
      check("undo_refill", 32'(bus_if.values), 32'h956);
      press_clear(20);
      check("hold_clear_values", 32'(bus_if.values), 32'hFFF);
      check("hold_clear_stage", 32'(bus_if.stage), 32'd0);
`else
      check("clear_values", 32'(bus_if.values), 32'hFFF);
      check("clear_stage", 32'(bus_if.stage), 32'd0);
      check("clear_valid", 32'(bus_if.triple_valid), 32'd0);
`endif

      // CLEAR and ENTER pressed together in GET_OP: CLEAR wins, sw not captured.
      press_enter(4'h2);
      check("pre_simul_values", 32'(bus_if.values), 32'hFF2);
      bus_if.sw   = 4'h7;
      key_enter_n = 1'b0;
      key_clear_n = 1'b0;
      tick(D + 8);
      key_enter_n = 1'b1;
      key_clear_n = 1'b1;
      tick(D + 10);
      check("simul_values", 32'(bus_if.values), 32'hFFF);
      check("simul_stage", 32'(bus_if.stage), 32'd0);
      check("final_err_count", 32'(err_pulses), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
